// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between functional units.
// The winning word is registered onto cdb one cycle after its handshake completes.
module cdb_arbiter #(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned CDB_W   = 36,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned GID_W  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_UNITS*CDB_W-1:0] req_data,
    input  logic [N_UNITS-1:0]       req_valid,
    output logic [N_UNITS-1:0]       req_ready,
    input  logic                     flush,
    output logic [CDB_W-1:0]         cdb,
    output logic                     cdb_valid,
    output logic [GID_W-1:0]         cdb_src,
    output logic [CNT_W-1:0]         contention_cnt
);

    logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CDB_W-1:0] cdb_q, cdb_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [GID_W-1:0] cdb_src_q, cdb_src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant_vld;
    logic [GID_W-1:0] grant_idx;
    logic [CDB_W-1:0] win_data;
    logic             contend;

    // Scan from rr_ptr upward (mod N_UNITS); the first valid unit wins.
    always_comb begin
        int unsigned idx;
        logic [GID_W-1:0] k;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        k         = '0;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            idx = (32'(rr_ptr_q) + i) % N_UNITS;
            k   = GID_W'(idx);
            if (!grant_vld && req_valid[k]) begin
                grant_vld = 1'b1;
                grant_idx = k;
            end
        end
        if (rst || flush) begin
            grant_vld = 1'b0;
            grant_idx = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        win_data  = '0;
        for (int unsigned k = 0; k < N_UNITS; k++) begin
            if (grant_vld && (grant_idx == GID_W'(k))) begin
                req_ready[k] = 1'b1;
                win_data     = req_data[k*CDB_W +: CDB_W];
            end
        end
    end

    assign contend = ($countones(req_valid) >= 2);

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_d       = '0;
        cdb_valid_d = 1'b0;
        cdb_src_d   = cdb_src_q;
        cnt_d       = cnt_q;
        if (grant_vld) begin
            cdb_d       = win_data;
            cdb_valid_d = 1'b1;
            cdb_src_d   = grant_idx;
            rr_ptr_d    = (grant_idx == GID_W'(N_UNITS - 1)) ? '0 : grant_idx + 1'b1;
        end
        // Saturate instead of wrapping so a long run never reads as low contention.
        if (contend && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            cnt_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_q       <= cdb_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cdb            = cdb_q;
    assign cdb_valid      = cdb_valid_q;
    assign cdb_src        = cdb_src_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by random traffic, all
// compared against a round-robin reference model kept in plain integers.
module tb_cdb_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 36;
    localparam int unsigned CW = 4;
    localparam int CMAX = 15;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic           flush;
    logic [W-1:0]   cdb;
    logic           cdb_valid;
    logic [1:0]     cdb_src;
    logic [CW-1:0]  contention_cnt;

    cdb_arbiter #(
        .N_UNITS (N),
        .CDB_W   (W),
        .CNT_W   (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .flush          (flush),
        .cdb            (cdb),
        .cdb_valid      (cdb_valid),
        .cdb_src        (cdb_src),
        .contention_cnt (contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_ptr = 0;
    int          m_cnt = 0;
    logic [W-1:0] m_cdb = '0;
    logic        m_vld = 1'b0;
    int          m_src = 0;

    logic [W-1:0] udata [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int ptr);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (ptr + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic int popcnt(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    // One clock: drive inputs, check handshake, clock, then check registered outputs.
    task automatic step(input logic [N-1:0] v, input logic f, input logic r);
        int g;
        logic [N-1:0] exp_ready;
        logic [63:0] t;
        req_valid = v;
        flush     = f;
        rst       = r;
        for (int k = 0; k < N; k++) req_data[k*W +: W] = udata[k];
        #2;
        g = (r || f) ? -1 : winner(v, m_ptr);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        if (r) begin
            m_ptr = 0; m_cnt = 0; m_cdb = '0; m_vld = 1'b0; m_src = 0;
        end else begin
            if (popcnt(v) >= 2 && m_cnt < CMAX) m_cnt++;
            if (g >= 0) begin
                m_cdb = udata[g]; m_vld = 1'b1; m_src = g; m_ptr = (g + 1) % N;
            end else begin
                m_cdb = '0; m_vld = 1'b0;
            end
        end
        chk("cdb", 64'(cdb), 64'(m_cdb));
        chk("cdb_valid", 64'(cdb_valid), 64'(m_vld));
        chk("cdb_src", 64'(cdb_src), 64'(m_src));
        chk("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
        // Units only present fresh data once the previous word has been taken.
        for (int k = 0; k < N; k++) begin
            if (!v[k] || exp_ready[k]) begin
                t = {$urandom(), $urandom()};
                udata[k] = t[W-1:0];
            end
        end
    endtask

    initial begin
        logic [63:0] t;
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int k = 0; k < N; k++) begin
            t = {$urandom(), $urandom()};
            udata[k] = t[W-1:0];
        end
        @(posedge clk);
        #1;

        // Reset held two cycles with everyone requesting
        step(4'hF, 1'b0, 1'b1);
        step(4'hF, 1'b0, 1'b1);
        chk("reset_cnt", 64'(contention_cnt), 64'd0);

        // Single word from unit 2
        udata[2] = 36'h3_DEADBEEF;
        step(4'b0100, 1'b0, 1'b0);
        chk("single_cdb", 64'(cdb), 64'h3_DEADBEEF);
        chk("single_src", 64'(cdb_src), 64'd2);
        step(4'b0000, 1'b0, 1'b0);
        chk("single_idle", 64'(cdb_valid), 64'd0);

        // All four valid from reset: strict rotation
        step(4'hF, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(4'hF, 1'b0, 1'b0);
            chk("rr_order", 64'(cdb_src), 64'(i % 4));
        end
        chk("rr_cnt8", 64'(contention_cnt), 64'd8);

        // Pointer to 2 via unit 1, then units 1 and 3 compete (wrap check)
        step(4'b0010, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b0);
        chk("wrap_first", 64'(cdb_src), 64'd3);
        step(4'b1010, 1'b0, 1'b0);
        chk("wrap_second", 64'(cdb_src), 64'd1);

        // Grant to unit 0, flush next cycle, pointer must not move
        step(4'b0001, 1'b0, 1'b0);
        step(4'hF, 1'b1, 1'b0);
        chk("flush_valid", 64'(cdb_valid), 64'd0);
        step(4'hF, 1'b0, 1'b0);
        chk("flush_ptr_held", 64'(cdb_src), 64'd1);

        // Counter saturation, then reset mid-stream
        for (int i = 0; i < 20; i++) step(4'b0011, 1'b0, 1'b0);
        chk("sat_cnt", 64'(contention_cnt), 64'd15);
        step(4'b0011, 1'b0, 1'b1);
        chk("rst_mid_cnt", 64'(contention_cnt), 64'd0);
        chk("rst_mid_valid", 64'(cdb_valid), 64'd0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
